data_mem_arbiter: RTL

//  Shares the single-port data memory between two requesters: port 0 (pipeline MEM stage)
//  and port 1 (loader/debug DMA). Arbitrates, checks alignment/range, drives the memory's

---
 rtl/data_mem_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: one access per grant, Done/Err pulse back.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed port-0 priority.
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Req0,
    input  logic                  i_Wr0,
    input  logic [1:0]            i_Cmd0,
    input  logic [ADDR_WIDTH-1:0] i_Addr0,
    input  logic [DATA_WIDTH-1:0] i_WData0,
    input  logic                  i_Req1,
    input  logic                  i_Wr1,
    input  logic [1:0]            i_Cmd1,
    input  logic [ADDR_WIDTH-1:0] i_Addr1,
    input  logic [DATA_WIDTH-1:0] i_WData1,
    output logic                  o_Done0,
    output logic                  o_Err0,
    output logic                  o_Done1,
    output logic                  o_Err1,
    output logic [DATA_WIDTH-1:0] o_RData,
    output logic                  o_Mem_R_en,
    output logic                  o_Mem_W_en,
    output logic [ADDR_WIDTH-1:0] o_Mem_Address,
    output logic [DATA_WIDTH-1:0] o_Mem_W_data,
    output logic [1:0]            o_Mem_ReadCommand,
    output logic [1:0]            o_Mem_WriteCommand,
    input  logic [DATA_WIDTH-1:0] i_Mem_R_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  r_id;
    logic                  r_err;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_RData;
    logic                  r_Mem_R_en;
    logic                  r_Mem_W_en;
    logic [ADDR_WIDTH-1:0] r_Mem_Address;
    logic [DATA_WIDTH-1:0] r_Mem_W_data;
    logic [1:0]            r_Mem_ReadCommand;
    logic [1:0]            r_Mem_WriteCommand;
`ifdef ARB_ROUND_ROBIN_EN
    logic                  r_last;
`endif

    logic                  w_req;
    logic                  w_sel;
    logic                  w_wr;
    logic [1:0]            w_cmd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_illegal;

    assign w_req = i_Req0 | i_Req1;

    always_comb begin
        w_sel = ~i_Req0;
`ifdef ARB_ROUND_ROBIN_EN
        // on contention grant whichever port did not win last
        if (i_Req0 && i_Req1) begin
            w_sel = ~r_last;
        end
`endif
    end

    assign w_wr    = w_sel ? i_Wr1    : i_Wr0;
    assign w_cmd   = w_sel ? i_Cmd1   : i_Cmd0;
    assign w_addr  = w_sel ? i_Addr1  : i_Addr0;
    assign w_wdata = w_sel ? i_WData1 : i_WData0;

    always_comb begin
        w_illegal = 1'b0;
        case (w_cmd)
            2'd0:    w_illegal = (w_addr[1:0] != 2'b00);
            2'd1:    w_illegal = w_addr[0];
            2'd2:    w_illegal = 1'b0;
            default: w_illegal = 1'b1;
        endcase
        if ((w_addr >> 2) >= ADDR_WIDTH'(MEM_WORDS)) begin
            w_illegal = 1'b1;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_Done0 = 1'b0;
        o_Done1 = 1'b0;
        o_Err0  = 1'b0;
        o_Err1  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = w_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                w_next  = S_IDLE;
                o_Done0 = ~r_id;
                o_Done1 = r_id;
                o_Err0  = ~r_id & r_err;
                o_Err1  = r_id & r_err;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_id               <= 1'b0;
            r_err              <= 1'b0;
            r_wr               <= 1'b0;
            r_RData            <= '0;
            r_Mem_R_en         <= 1'b0;
            r_Mem_W_en         <= 1'b0;
            r_Mem_Address      <= '0;
            r_Mem_W_data       <= '0;
            r_Mem_ReadCommand  <= '0;
            r_Mem_WriteCommand <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last             <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_id  <= w_sel;
                        r_err <= w_illegal;
                        r_wr  <= w_wr;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last <= w_sel;
`endif
                        // rejected requests leave every memory pin untouched
                        if (!w_illegal) begin
                            r_Mem_Address <= w_addr;
                            r_Mem_R_en    <= ~w_wr;
                            r_Mem_W_en    <= w_wr;
                            if (w_wr) begin
                                r_Mem_W_data       <= w_wdata;
                                r_Mem_WriteCommand <= w_cmd;
                            end else begin
                                r_Mem_ReadCommand  <= w_cmd;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_wr) begin
                        r_RData <= i_Mem_R_data;
                    end
                    r_Mem_R_en <= 1'b0;
                    r_Mem_W_en <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_RData            = r_RData;
    assign o_Mem_R_en         = r_Mem_R_en;
    assign o_Mem_W_en         = r_Mem_W_en;
    assign o_Mem_Address      = r_Mem_Address;
    assign o_Mem_W_data       = r_Mem_W_data;
    assign o_Mem_ReadCommand  = r_Mem_ReadCommand;
    assign o_Mem_WriteCommand = r_Mem_WriteCommand;

endmodule
